// File: rtl/linreg_pkg.sv
// Shared widths, default coefficients and state encoding
// for the sequential linear-regression evaluator.
package linreg_pkg;
    localparam int FEAT_W = 16;
    localparam int ACC_W  = 32;
    localparam int IDX_W  = 4;

    localparam logic [FEAT_W-1:0] C0_DEF = 16'h0000;
    localparam logic [FEAT_W-1:0] C1_DEF = 16'h02CD;
    localparam logic [FEAT_W-1:0] C2_DEF = 16'h8FD8;
    localparam logic [FEAT_W-1:0] C3_DEF = 16'hFDE8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;
endpackage

// File: rtl/linreg_mac_seq_if.sv
// Feature-in / price-out handshake bundle.
// Master is the feature source plus price consumer.
interface linreg_mac_seq_if;
    import linreg_pkg::*;

    logic              x_valid;
    logic              x_ready;
    logic [FEAT_W-1:0] x_data;
    logic              x_last;
    logic              price_valid;
    logic              price_ready;
    logic [ACC_W-1:0]  price;
    logic              rout;
    logic              frame_err;

    modport master (
        output x_valid, x_data, x_last, price_ready,
        input  x_ready, price_valid, price, rout, frame_err
    );

    modport slave (
        input  x_valid, x_data, x_last, price_ready,
        output x_ready, price_valid, price, rout, frame_err
    );
endinterface

// File: rtl/add_seize.sv
// Unsigned W-bit adder with carry-in and carry-out,
// chained to build wider accumulators.
module add_seize #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         rout
);
    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign rout = full[W];
endmodule

// File: rtl/multiplier_seize.sv
// Unsigned W x W multiplier with a full 2W-bit product.
// rout flags product overflow; the full-width product never overflows.
module multiplier_seize #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           rout
);
    assign p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign rout = 1'b0;
endmodule

// File: rtl/linreg_mac_seq.sv
// Sequential linear-regression evaluator: one MAC per feature beat,
// result held in OUT until the consumer takes it.
module linreg_mac_seq
    import linreg_pkg::*;
#(
    parameter int unsigned       N_FEAT = 3,
    parameter logic [FEAT_W-1:0] C0     = C0_DEF,
    parameter logic [FEAT_W-1:0] C1     = C1_DEF,
    parameter logic [FEAT_W-1:0] C2     = C2_DEF,
    parameter logic [FEAT_W-1:0] C3     = C3_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    linreg_mac_seq_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [ACC_W-1:0] ACC_INIT = {16'h0000, C0};

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;

    logic [FEAT_W-1:0]  coef;
    logic [ACC_W-1:0]   prod;
    logic [ACC_W-1:0]   sum;
    logic               c_lo;
    logic               c_hi;
    logic               mul_rout_unused;
    logic               take;
    logic               at_last;

    always_comb begin
        coef = '0;
        case (idx_q)
            4'd0:    coef = C1;
            4'd1:    coef = C2;
            4'd2:    coef = C3;
            default: coef = '0;
        endcase
    end

    multiplier_seize #(.W(FEAT_W)) u_mul (
        .a    (coef),
        .b    (bus.x_data),
        .p    (prod),
        .rout (mul_rout_unused)
    );

    add_seize #(.W(16)) u_add_lo (
        .a    (acc_q[15:0]),
        .b    (prod[15:0]),
        .cin  (1'b0),
        .sum  (sum[15:0]),
        .rout (c_lo)
    );

    add_seize #(.W(16)) u_add_hi (
        .a    (acc_q[31:16]),
        .b    (prod[31:16]),
        .cin  (c_lo),
        .sum  (sum[31:16]),
        .rout (c_hi)
    );

    assign take    = bus.x_valid && (state_q == ACC);
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            ACC: begin
                if (take) begin
                    acc_d   = sum;
                    carry_d = carry_q | c_hi;
                    idx_d   = idx_q + 4'd1;
                    if (at_last || bus.x_last) begin
                        // mismatch between count and marker flags the frame
                        err_d   = at_last ^ bus.x_last;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.price_ready) begin
                    state_d = ACC;
                    acc_d   = ACC_INIT;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= ACC_INIT;
            idx_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign bus.x_ready     = (state_q == ACC);
    assign bus.price_valid = (state_q == OUT);
    assign bus.price       = acc_q;
    assign bus.rout        = carry_q;
    assign bus.frame_err   = err_q;
endmodule

// File: tb/tb_linreg_mac_seq.sv
// Directed bench for linreg_mac_seq with hand-computed prices.
// Default coefficients 02CD, 8FD8, FDE8; intercept 0.
module tb_linreg_mac_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    linreg_mac_seq_if bus ();

    linreg_mac_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        bus.x_valid = 1'b1;
        bus.x_data  = d;
        bus.x_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_xrdy"}, 32'(bus.x_ready), 32'd1);
        chk({tag, "_pvld"}, 32'(bus.price_valid), 32'd0);
        chk({tag, "_price"}, bus.price, 32'h0);
        chk({tag, "_rout"}, 32'(bus.rout), 32'd0);
        chk({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.x_last  = 1'b0;
        bus.price_ready = 1'b1;
        step();
        step();
        chk_idle("rst");
        rst_n = 1'b1;

        // 100*717 + 4*36824 + 1*65000 = 283996
        beat(16'd100, 1'b0);
        beat(16'd4, 1'b0);
        chk("f1_pvld_early", 32'(bus.price_valid), 32'd0);
        beat(16'd1, 1'b1);
        bus.x_valid = 1'b0;
        chk("f1_pvld", 32'(bus.price_valid), 32'd1);
        chk("f1_xrdy", 32'(bus.x_ready), 32'd0);
        chk("f1_price", bus.price, 32'h0004555C);
        chk("f1_rout", 32'(bus.rout), 32'd0);
        chk("f1_ferr", 32'(bus.frame_err), 32'd0);
        step();
        chk("f1_back_acc", 32'(bus.x_ready), 32'd1);
        chk("f1_pvld_drop", 32'(bus.price_valid), 32'd0);

        // 02CCFD33 + 8FD77028 + FDE70218 wraps once
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b1);
        bus.x_valid = 1'b0;
        chk("f2_price", bus.price, 32'h908B6F73);
        chk("f2_rout", 32'(bus.rout), 32'd1);
        chk("f2_ferr", 32'(bus.frame_err), 32'd0);
        step();

        // early x_last on beat 1
        beat(16'd100, 1'b0);
        beat(16'd4, 1'b1);
        bus.x_valid = 1'b0;
        chk("f3_pvld", 32'(bus.price_valid), 32'd1);
        chk("f3_price", bus.price, 32'h00035774);
        chk("f3_ferr", 32'(bus.frame_err), 32'd1);
        chk("f3_rout", 32'(bus.rout), 32'd0);
        step();

        // missing x_last on final beat
        beat(16'd100, 1'b0);
        beat(16'd4, 1'b0);
        beat(16'd1, 1'b0);
        bus.x_valid = 1'b0;
        chk("f4_pvld", 32'(bus.price_valid), 32'd1);
        chk("f4_price", bus.price, 32'h0004555C);
        chk("f4_ferr", 32'(bus.frame_err), 32'd1);
        step();
        chk("f4_ferr_clr", 32'(bus.frame_err), 32'd0);

        // 1*717 + 2*36824 + 3*65000 = 269365, consumer stalls
        bus.price_ready = 1'b0;
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        beat(16'd3, 1'b1);
        bus.x_data  = 16'd2;
        bus.x_last  = 1'b0;
        chk("f5a_price", bus.price, 32'h00041C35);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("f5_hold_price", bus.price, 32'h00041C35);
            chk("f5_hold_xrdy", 32'(bus.x_ready), 32'd0);
            chk("f5_hold_pvld", 32'(bus.price_valid), 32'd1);
        end
        bus.price_ready = 1'b1;
        step();
        chk("f5_release", 32'(bus.price_valid), 32'd0);
        // 2*717 + 0 + 16*65000 = 1041434
        beat(16'd2, 1'b0);
        beat(16'd0, 1'b0);
        beat(16'h0010, 1'b1);
        bus.x_valid = 1'b0;
        chk("f5b_pvld", 32'(bus.price_valid), 32'd1);
        chk("f5b_price", bus.price, 32'h000FE41A);
        chk("f5b_ferr", 32'(bus.frame_err), 32'd0);
        step();

        // reset mid-frame discards partial sum
        beat(16'd100, 1'b0);
        beat(16'd4, 1'b0);
        bus.x_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk_idle("midrst");
        rst_n = 1'b1;
        beat(16'd100, 1'b0);
        beat(16'd4, 1'b0);
        beat(16'd1, 1'b1);
        bus.x_valid = 1'b0;
        chk("f6_price", bus.price, 32'h0004555C);
        chk("f6_ferr", 32'(bus.frame_err), 32'd0);
        chk("f6_rout", 32'(bus.rout), 32'd0);

        // reset while holding a result
        bus.price_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle("outrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
